// File: rtl/ring_counter_4.sv
// One-hot ring counter used as a phase/sequence generator. Self-starting: any
// state that is not exactly one-hot (including X at power-up) becomes INIT on the next edge.
module ring_counter_4 #(
  parameter int         WIDTH = 4,
  parameter logic [3:0] INIT  = 4'b0001,
  parameter bit         DIR   = 1'b0
) (
  input  logic             reset,
  input  logic             clock,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Only the four legal codes rotate; anything else, X included, lands in default.
  always_comb begin
    state_next = INIT;
    case (state)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        if (DIR) begin
          state_next = {state[0], state[WIDTH-1:1]};
        end else begin
          state_next = {state[WIDTH-2:0], state[WIDTH-1]};
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign out = state;

endmodule

// File: tb/tb_ring_counter_4.sv
// Bench for ring_counter_4: a position-based model (index 0..3, modular step)
// is compared every cycle against a left-rotating and a right-rotating instance.
module tb_ring_counter_4;

  logic       clock = 1'b1;
  logic       reset = 1'b0;
  logic [3:0] out0;
  logic [3:0] out1;

  ring_counter_4 #(.WIDTH(4), .INIT(4'b0001), .DIR(1'b0)) dut0 (
    .reset(reset), .clock(clock), .out(out0)
  );
  ring_counter_4 #(.WIDTH(4), .INIT(4'b0001), .DIR(1'b1)) dut1 (
    .reset(reset), .clock(clock), .out(out1)
  );

  initial forever #50 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: position of the single '1'; bad flags mark a state the model knows is illegal.
  int p0    = 0;
  int p1    = 0;
  int edges = 0;
  bit bad0  = 1'b1;
  bit bad1  = 1'b1;

  always @(posedge clock) begin
    if (reset || bad0) p0 <= 0;
    else               p0 <= (p0 + 1) % 4;
    if (reset || bad1) p1 <= 0;
    else               p1 <= (p1 + 3) % 4;
    edges <= edges + 1;
  end

  always @(negedge clock) begin
    if (edges > 0) begin
      check("model_dir0", out0, 4'(1 << p0));
      check("model_dir1", out1, 4'(1 << p1));
      check("onehot_dir0", 4'($countones(out0)), 4'd1);
      check("onehot_dir1", 4'($countones(out1)), 4'd1);
    end
  end

  logic [3:0] pw0 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] pw1 [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin
    // Power-up without reset: first edge at t=100 resolves to INIT.
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) begin
        bad0 = 1'b0;
        bad1 = 1'b0;
      end
      check("pwrup_dir0", out0, pw0[i]);
      check("pwrup_dir1", out1, pw1[i]);
    end
    repeat (5) @(negedge clock);

    // Synchronous reset asserted between edges must not act until the next edge.
    #20 reset = 1'b1;
    #10 check("rst_no_async", out0, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_hold", out0, 4'b0001);
    end
    reset = 1'b0;
    @(negedge clock);
    check("rst_release", out0, 4'b0010);
    check("dir1_seq0", out1, 4'b1000);
    @(negedge clock);
    check("dir1_seq1", out1, 4'b0100);
    @(negedge clock);
    check("dir1_seq2", out1, 4'b0010);
    @(negedge clock);
    check("dir1_seq3", out1, 4'b0001);
    @(negedge clock);
    check("dir1_seq4", out1, 4'b1000);

    // Reset mid-sequence from 0100.
    @(negedge clock);
    check("mid_pos", out0, 4'b0100);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst", out0, 4'b0001);
    reset = 1'b0;
    @(negedge clock);
    check("mid_next", out0, 4'b0010);

    // Illegal-state recovery.
    #5 force dut0.state = 4'b0000;
    bad0 = 1'b1;
    #5 release dut0.state;
    @(negedge clock);
    bad0 = 1'b0;
    check("ill_0000", out0, 4'b0001);
    @(negedge clock);
    check("ill_0000_next", out0, 4'b0010);

    #5 force dut0.state = 4'b0110;
    bad0 = 1'b1;
    #5 release dut0.state;
    @(negedge clock);
    bad0 = 1'b0;
    check("ill_0110", out0, 4'b0001);
    @(negedge clock);
    check("ill_0110_next", out0, 4'b0010);

    #5 force dut0.state = 4'b1111;
    bad0 = 1'b1;
    #5 release dut0.state;
    @(negedge clock);
    bad0 = 1'b0;
    check("ill_1111", out0, 4'b0001);
    @(negedge clock);
    check("ill_1111_next", out0, 4'b0010);

    // Random resets; the compare process checks model and one-hot every cycle.
    repeat (100) begin
      @(negedge clock);
      reset = ($urandom_range(0, 3) == 0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
